bird_sprite_draw: RTL and testbench

Pixel-pipeline consumer of the 16x16 bird sprite ROM. It maps the current video-scan coordinate into sprite row/col addresses and drives them to the ROM. It absorbs the ROM's 1-cycle registered read latency and composites the returned pixel over the background, treating the transparent key as "show background". It also produces a per-frame sticky collision flag for the game FSM. It sits between the VGA timing/background generators and the RGB output register.

---
 rtl/bird_sprite_draw.sv | 107 ++++++++++
 tb/tb_bird_sprite_draw.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/bird_sprite_draw.sv
// Bird sprite compositor: maps scan coordinates onto the 16x16 sprite ROM, absorbs its
// one-cycle read latency, overlays opaque pixels on the background and tracks per-frame collisions.
module bird_sprite_draw #(
  parameter int          SCALE_SHIFT = 1,
  parameter logic [11:0] TRANSPARENT = 12'h0FF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic [9:0]  bird_x,
  input  logic [9:0]  bird_y,
  input  logic        pix_valid,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic [11:0] bg_rgb,
  input  logic        bg_solid,
  output logic [3:0]  rom_row,
  output logic [3:0]  rom_col,
  input  logic [11:0] rom_pixel,
  output logic        out_valid,
  output logic [11:0] out_rgb,
  output logic        out_hit,
  output logic        collide
);

  // Valid semantics: out_valid qualifies out_rgb/out_hit for exactly one cycle; there is
  // no ready/backpressure, so one pixel enters and one leaves every clock, 2 cycles apart.

  localparam logic [10:0] BOX = 11'(16 << SCALE_SHIFT);

  logic [9:0]  lat_x, lat_y;
  logic [10:0] dx, dy;
  logic        in_box;

  logic        s1_valid, s1_in_box, s1_bg_solid;
  logic [11:0] s1_bg_rgb;
  logic        opaque, hit_now, acc;

  // Sprite position only changes between frames; same-cycle pixels still see the old one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_x <= '0;
      lat_y <= '0;
    end else if (frame_start) begin
      lat_x <= bird_x;
      lat_y <= bird_y;
    end
  end

  // Stage 0: the sign bit of the 11-bit difference clips pixels left of / above the sprite.
  always_comb begin
    dx      = {1'b0, pix_x} - {1'b0, lat_x};
    dy      = {1'b0, pix_y} - {1'b0, lat_y};
    in_box  = pix_valid && !dx[10] && (dx < BOX) && !dy[10] && (dy < BOX);
    rom_col = in_box ? dx[SCALE_SHIFT+3:SCALE_SHIFT] : 4'd0;
    rom_row = in_box ? dy[SCALE_SHIFT+3:SCALE_SHIFT] : 4'd0;
  end

  // Stage 1: background side-band delayed to line up with the ROM's registered data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_in_box   <= 1'b0;
      s1_bg_rgb   <= '0;
      s1_bg_solid <= 1'b0;
    end else begin
      s1_valid    <= pix_valid;
      s1_in_box   <= in_box;
      s1_bg_rgb   <= bg_rgb;
      s1_bg_solid <= bg_solid;
    end
  end

  always_comb begin
    opaque  = s1_in_box && (rom_pixel != TRANSPARENT);
    hit_now = opaque && s1_bg_solid;
  end

  // Blanking cycles output black so the RGB register never carries stale colour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_rgb   <= '0;
      out_hit   <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      out_hit   <= s1_valid && opaque;
      if (!s1_valid)   out_rgb <= '0;
      else if (opaque) out_rgb <= rom_pixel;
      else             out_rgb <= s1_bg_rgb;
    end
  end

  // A hit arriving with frame_start belongs to the closing frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= 1'b0;
      collide <= 1'b0;
    end else if (frame_start) begin
      collide <= acc || hit_now;
      acc     <= 1'b0;
    end else if (hit_now) begin
      acc <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bird_sprite_draw.sv
// Directed bench for bird_sprite_draw: a local sprite ROM model, a driver that queues
// hand-computed expectations, and a monitor that pops them as out_valid pixels appear.
module tb_bird_sprite_draw;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_start;
  logic [9:0]  bird_x, bird_y;
  logic        pix_valid;
  logic [9:0]  pix_x, pix_y;
  logic [11:0] bg_rgb;
  logic        bg_solid;
  logic [3:0]  rom_row, rom_col;
  logic [11:0] rom_pixel = 12'h000;
  logic        out_valid;
  logic [11:0] out_rgb;
  logic        out_hit;
  logic        collide;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  logic [12:0] exp_q[$];
  int          lat_q[$];

  bird_sprite_draw #(.SCALE_SHIFT(1), .TRANSPARENT(12'h0FF)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .bird_x(bird_x), .bird_y(bird_y),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .bg_rgb(bg_rgb), .bg_solid(bg_solid),
    .rom_row(rom_row), .rom_col(rom_col), .rom_pixel(rom_pixel),
    .out_valid(out_valid), .out_rgb(out_rgb), .out_hit(out_hit),
    .collide(collide)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- sprite ROM model (registered read) ----------------
  function automatic logic [11:0] rom_f(input logic [3:0] r, input logic [3:0] c);
    if (r == 4'd3 && c == 4'd5)                         return 12'hFFF;  // eye white
    else if (r == 4'd6 && c == 4'd4)                    return 12'hF80;  // beak
    else if (r == 4'd8)                                 return 12'h8A0;  // wing stripe
    else if (r >= 4'd2 && r <= 4'd13 && c >= 4'd2 && c <= 4'd13) return 12'hFE0;
    else                                                return 12'h0FF;
  endfunction

  always @(posedge clk) rom_pixel <= rom_f(rom_row, rom_col);

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got rgb %0h required no output", out_rgb);
      end else begin
        logic [12:0] e;
        int          l;
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        chk("out_rgb", {20'd0, out_rgb}, {20'd0, e[11:0]});
        chk("out_hit", {31'd0, out_hit}, {31'd0, e[12]});
        chk("latency", cyc_cnt - l, 32'd2);
      end
    end else begin
      chk("blank_black", {19'd0, out_hit, out_rgb}, 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic v, input logic [9:0] x, input logic [9:0] y,
                     input logic [11:0] bg, input logic solid, input logic fs,
                     input logic [9:0] bx, input logic [9:0] by,
                     input logic [11:0] er, input logic eh);
    @(posedge clk); #1;
    pix_valid = v; pix_x = x; pix_y = y; bg_rgb = bg; bg_solid = solid;
    frame_start = fs; bird_x = bx; bird_y = by;
    if (v) begin
      exp_q.push_back({eh, er});
      lat_q.push_back(cyc_cnt);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 10'd0, 10'd0, 12'h000, 1'b0, 1'b0, 10'd0, 10'd0, 12'h000, 1'b0);
  endtask

  task automatic frame(input logic [9:0] bx, input logic [9:0] by);
    cyc(1'b0, 10'd0, 10'd0, 12'h000, 1'b0, 1'b1, bx, by, 12'h000, 1'b0);
  endtask

  task automatic px(input logic [9:0] x, input logic [9:0] y, input logic [11:0] bg,
                    input logic solid, input logic [11:0] er, input logic eh);
    cyc(1'b1, x, y, bg, solid, 1'b0, 10'd0, 10'd0, er, eh);
  endtask

  task automatic pxa(input logic [9:0] x, input logic [9:0] y, input logic [11:0] bg,
                     input logic [11:0] er, input logic eh,
                     input logic [3:0] er_row, input logic [3:0] er_col);
    px(x, y, bg, 1'b0, er, eh);
    #1;
    chk("rom_row", {28'd0, rom_row}, {28'd0, er_row});
    chk("rom_col", {28'd0, rom_col}, {28'd0, er_col});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; frame_start = 1'b0; bird_x = '0; bird_y = '0;
    pix_valid = 1'b0; pix_x = '0; pix_y = '0; bg_rgb = '0; bg_solid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_rom_row", {28'd0, rom_row}, 32'd0);
    chk("rst_rom_col", {28'd0, rom_col}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_rgb", {20'd0, out_rgb}, 32'd0);
    chk("rst_out_hit", {31'd0, out_hit}, 32'd0);
    chk("rst_collide", {31'd0, collide}, 32'd0);
    rst_n = 1'b1;
    idle(3);
    chk("idle_out_valid", {31'd0, out_valid}, 32'd0);

    // frame_start with a same-cycle pixel: (16,16) uses old position (0,0) -> row 8 col 8
    cyc(1'b1, 10'd16, 10'd16, 12'h0AB, 1'b0, 1'b1, 10'd100, 10'd50, 12'h8A0, 1'b1);
    pxa(10'd110, 10'd56, 12'h123, 12'hFFF, 1'b1, 4'd3, 4'd5);
    pxa(10'd100, 10'd50, 12'h4CF, 12'h4CF, 1'b0, 4'd0, 4'd0);
    px(10'd131, 10'd50, 12'h111, 1'b0, 12'h111, 1'b0);
    px(10'd132, 10'd50, 12'h222, 1'b0, 12'h222, 1'b0);
    px(10'd110, 10'd60, 12'h0AA, 1'b0, 12'hFE0, 1'b1);
    px(10'd16, 10'd16, 12'h0AC, 1'b0, 12'h0AC, 1'b0);
    idle(3);

    // right-edge clipping: sprite at x=1020 must not wrap to the left edge
    frame(10'd1020, 10'd200);
    for (int i = 0; i < 3; i++)
      px(10'(1021 + i), 10'd216, 12'(12'h500 + i), 1'b0, 12'h8A0, 1'b1);
    for (int i = 0; i <= 10; i++)
      px(10'(i), 10'd216, 12'(12'h600 + i), 1'b0, 12'(12'h600 + i), 1'b0);
    idle(3);

    // back-to-back stream outside the sprite: output is input delayed by 2, no gaps
    frame(10'd100, 10'd50);
    for (int i = 0; i < 20; i++)
      px(10'(200 + i), 10'd400, 12'(12'h300 + i), 1'b0, 12'(12'h300 + i), 1'b0);
    idle(3);

    // collision: beak over a solid background
    frame(10'd100, 10'd50);
    idle(1);
    chk("collide_clear", {31'd0, collide}, 32'd0);
    px(10'd108, 10'd62, 12'h0C0, 1'b1, 12'hF80, 1'b1);
    idle(2);
    frame(10'd100, 10'd50);
    idle(1);
    chk("collide_beak", {31'd0, collide}, 32'd1);
    px(10'd10, 10'd10, 12'h0A0, 1'b1, 12'h0A0, 1'b0);
    px(10'd110, 10'd60, 12'h0BB, 1'b0, 12'hFE0, 1'b1);
    idle(2);
    frame(10'd100, 10'd50);
    idle(1);
    chk("collide_none", {31'd0, collide}, 32'd0);
    px(10'd108, 10'd62, 12'h0C1, 1'b1, 12'hF80, 1'b1);
    frame(10'd100, 10'd50);
    idle(1);
    chk("collide_same_cycle", {31'd0, collide}, 32'd1);
    idle(2);
    frame(10'd100, 10'd50);
    idle(1);
    chk("collide_not_carried", {31'd0, collide}, 32'd0);

    // reset mid-frame discards both the sticky flag and the pending accumulator
    px(10'd108, 10'd62, 12'h0C2, 1'b1, 12'hF80, 1'b1);
    idle(2);
    frame(10'd100, 10'd50);
    idle(1);
    chk("collide_pre_reset", {31'd0, collide}, 32'd1);
    px(10'd108, 10'd62, 12'h0C3, 1'b1, 12'hF80, 1'b1);
    idle(3);
    rst_n = 1'b0;
    #1;
    chk("midrst_collide", {31'd0, collide}, 32'd0);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    frame(10'd100, 10'd50);
    idle(1);
    chk("collide_after_reset", {31'd0, collide}, 32'd0);
    px(10'd108, 10'd62, 12'h0C4, 1'b0, 12'hF80, 1'b1);
    idle(4);

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
